current_bias_calib_multi: RTL

Multi-channel ADC offset (bias) calibrator for the motor current path.
- On `start`, discards SETTLE conversions, then averages 2^LOG2_N conversions per channel.
- Publishes each channel's bias after a range check, with per-channel error flags and an abort input.
- Sits between the ADC interface and the current-loop offset subtractors; run once at power-up and on demand.

---
 rtl/current_bias_calib_multi.sv | 137 +++++++++++++
 1 files changed

// File: rtl/current_bias_calib_multi.sv
// Multi-channel ADC offset calibrator: discard SETTLE conversions, average 2^LOG2_N per
// channel, publish in-range averages as bias with per-channel out-of-range flags.

module current_bias_calib_lane #(
  parameter int W      = 12,
  parameter int LOG2_N = 8,
  parameter int LIMIT  = 400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         add,
  input  logic         fin,
  input  logic [W-1:0] sample,
  output logic [W-1:0] bias,
  output logic         err_ch,
  output logic         oor
);
  localparam int AW = W + LOG2_N;
  localparam logic signed [W:0] LIM = (W+1)'(LIMIT);

  logic [AW-1:0]   acc;
  logic signed [W:0] avg_x;

  // Dropping the low LOG2_N bits of a two's-complement sum floors toward -inf.
  assign avg_x = {acc[AW-1], acc[AW-1:LOG2_N]};
  assign oor   = (avg_x > LIM) || (avg_x < -LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      bias   <= '0;
      err_ch <= 1'b0;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= acc + {{LOG2_N{sample[W-1]}}, sample};
      if (fin) begin
        err_ch <= oor;
        if (!oor) bias <= avg_x[W-1:0];
      end
    end
  end
endmodule

module current_bias_calib_multi #(
  parameter int CH     = 3,
  parameter int W      = 12,
  parameter int LOG2_N = 8,
  parameter int SETTLE = 2000,
  parameter int LIMIT  = 400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          adc_rdy,
  input  logic [CH*W-1:0] adc_data,
  output logic [CH*W-1:0] bias,
  output logic          busy,
  output logic          rdy,
  output logic          err,
  output logic [CH-1:0] err_ch
);
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int N_SMP = 1 << LOG2_N;

  typedef enum logic [1:0] {IDLE, SETL, ACC, DONE} state_t;

  state_t        state;
  logic [SW-1:0] set_cnt;
  logic [LOG2_N:0] smp_cnt;
  logic [CH-1:0] oor;
  logic          clr, add, fin;

  // Accumulators sit cleared while idle, so every entry into ACC starts from zero.
  assign clr  = (state == IDLE);
  assign add  = (state == ACC) && adc_rdy && !abort;
  assign fin  = (state == DONE);
  assign busy = (state != IDLE);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    current_bias_calib_lane #(.W(W), .LOG2_N(LOG2_N), .LIMIT(LIMIT)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .add    (add),
      .fin    (fin),
      .sample (adc_data[i*W +: W]),
      .bias   (bias[i*W +: W]),
      .err_ch (err_ch[i]),
      .oor    (oor[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      set_cnt <= '0;
      smp_cnt <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          if (SETTLE == 0) begin
            state   <= ACC;
            smp_cnt <= (LOG2_N+1)'(N_SMP);
          end else begin
            state   <= SETL;
            set_cnt <= SW'(SETTLE);
          end
        end
        SETL: if (abort) state <= IDLE;
          else if (adc_rdy) begin
            set_cnt <= set_cnt - 1'b1;
            if (set_cnt == SW'(1)) begin
              state   <= ACC;
              smp_cnt <= (LOG2_N+1)'(N_SMP);
            end
          end
        ACC: if (abort) state <= IDLE;
          else if (adc_rdy) begin
            smp_cnt <= smp_cnt - 1'b1;
            if (smp_cnt == (LOG2_N+1)'(1)) state <= DONE;
          end
        // Completion wins over a late abort.
        DONE: begin
          state <= IDLE;
          rdy   <= 1'b1;
          err   <= |oor;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
